// File: rtl/fir_engine_if.sv
// fir_engine_if: start/size controls, sample/coef RAM read ports and result RAM write port of the FIR engine.
interface fir_engine_if #(
    parameter int ADDR_WIDTH   = 13,
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int RESULT_WIDTH = 21,
    parameter int TAP_WIDTH    = 6
) ();
    logic                           start;
    logic [ADDR_WIDTH-1:0]          num_samples;
    logic [TAP_WIDTH-1:0]           num_taps;
    logic [ADDR_WIDTH-1:0]          sample_addr;
    logic signed [SAMPLE_WIDTH-1:0] sample_data;
    logic [ADDR_WIDTH-1:0]          coef_addr;
    logic signed [COEF_WIDTH-1:0]   coef_data;
    logic                           sel_mux_wej;
    logic                           sel_mux_wyj;
    logic [ADDR_WIDTH-1:0]          result_addr;
    logic signed [RESULT_WIDTH-1:0] result_data;
    logic                           result_wr;
    logic                           busy;
    logic                           done;

    modport master (
        output start, num_samples, num_taps, sample_data, coef_data,
        input  sample_addr, coef_addr, sel_mux_wej, sel_mux_wyj,
               result_addr, result_data, result_wr, busy, done
    );

    modport slave (
        input  start, num_samples, num_taps, sample_data, coef_data,
        output sample_addr, coef_addr, sel_mux_wej, sel_mux_wyj,
               result_addr, result_data, result_wr, busy, done
    );
endinterface

// File: rtl/fir_engine.sv
// fir_engine: one-tap-per-cycle FIR over the sample/coef RAMs; scales, saturates and writes one result per output.
module fir_engine #(
    parameter int ADDR_WIDTH   = 13,
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int RESULT_WIDTH = 21,
    parameter int TAP_WIDTH    = 6,
    parameter int ACC_WIDTH    = 40,
    parameter int SHIFT        = 15
) (
    input logic a_clk,
    input logic a_rst_n,
    fir_engine_if.slave bus
);
    localparam int PW = SAMPLE_WIDTH + COEF_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                         r_state, w_next;
    logic [ADDR_WIDTH-1:0]          r_n, r_nlast;
    logic [TAP_WIDTH-1:0]           r_k, r_klast;
    logic                           r_tv;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic [ADDR_WIDTH-1:0]          w_k;
    logic                           w_tap_ok;
    logic                           w_zero;
    logic                           w_go;
    logic signed [PW-1:0]           w_mul;
    logic signed [ACC_WIDTH-1:0]    w_shift;
    logic                           w_ovf;
    logic signed [RESULT_WIDTH-1:0] w_sat;

    assign w_k      = ADDR_WIDTH'(r_k);
    assign w_tap_ok = w_k <= r_n;
    assign w_zero   = (bus.num_samples == '0) || (bus.num_taps == '0);
    assign w_go     = (r_state == S_IDLE) && bus.start && !w_zero;
    assign w_mul    = PW'(bus.sample_data) * PW'(bus.coef_data);
    assign w_shift  = r_acc >>> SHIFT;
    // Saturate when the bits above the result sign bit are not a pure sign extension.
    assign w_ovf    = !((&w_shift[ACC_WIDTH-1:RESULT_WIDTH-1]) || !(|w_shift[ACC_WIDTH-1:RESULT_WIDTH-1]));
    assign w_sat    = w_ovf ? {w_shift[ACC_WIDTH-1], {(RESULT_WIDTH-1){~w_shift[ACC_WIDTH-1]}}}
                            : w_shift[RESULT_WIDTH-1:0];

    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.start ? (w_zero ? S_DONE : S_RUN) : S_IDLE;
            S_RUN:   w_next = (r_k == r_klast) ? S_DRAIN : S_RUN;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: w_next = (r_n == r_nlast) ? S_DONE : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_WRITE);
        bus.sel_mux_wej = bus.busy;
        bus.sel_mux_wyj = bus.busy;
        bus.done        = r_state == S_DONE;
        bus.coef_addr   = (r_state == S_RUN) ? w_k : '0;
        bus.sample_addr = (r_state == S_RUN) && w_tap_ok ? r_n - w_k : '0;
        bus.result_wr   = r_state == S_WRITE;
        bus.result_addr = (r_state == S_WRITE) ? r_n : '0;
        bus.result_data = (r_state == S_WRITE) ? w_sat : '0;
    end

    // Taps with k > n never set tap_valid, so they add nothing to the accumulator.
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_n     <= '0;
            r_nlast <= '0;
            r_k     <= '0;
            r_klast <= '0;
            r_tv    <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_tv <= (r_state == S_RUN) && w_tap_ok;
            if (w_go) begin
                r_nlast <= bus.num_samples - 1'b1;
                r_klast <= bus.num_taps - 1'b1;
                r_n     <= '0;
                r_k     <= '0;
                r_acc   <= '0;
            end else if (r_state == S_WRITE) begin
                r_n   <= r_n + 1'b1;
                r_k   <= '0;
                r_acc <= '0;
            end else begin
                if (r_state == S_RUN) r_k <= r_k + 1'b1;
                if (r_tv) r_acc <= r_acc + ACC_WIDTH'(w_mul);
            end
        end
    end
endmodule

// File: tb/tb_fir_engine.sv
// tb_fir_engine: directed tests of fir_engine against hand-computed results and cycle timing.
module tb_fir_engine;
    logic a_clk;
    logic a_rst_n;
    int   checks;
    int   errs;

    fir_engine_if bus ();

    fir_engine dut (
        .a_clk   (a_clk),
        .a_rst_n (a_rst_n),
        .bus     (bus)
    );

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    logic signed [15:0] xmem [0:8191];
    logic signed [15:0] hmem [0:8191];
    logic signed [20:0] ymem [0:8191];

    always @(posedge a_clk) begin
        bus.sample_data <= xmem[bus.sample_addr];
        bus.coef_data   <= hmem[bus.coef_addr];
    end

    int wr_cyc[$];
    int dcyc, busy_first, busy_last, busy_cnt, sel_bad;

    task automatic clear_y();
        for (int i = 0; i < 64; i++) ymem[i] = 21'h0AAAAA;
    endtask

    task automatic run(input int n, input int t, input int sp);
        wr_cyc.delete();
        dcyc = 0; busy_first = 0; busy_last = 0; busy_cnt = 0; sel_bad = 0;
        @(negedge a_clk);
        bus.num_samples = 13'(n);
        bus.num_taps    = 6'(t);
        bus.start       = 1'b1;
        for (int c = 1; c <= 20000; c++) begin
            @(negedge a_clk);
            bus.start = (c == sp);
            if (c == sp) bus.num_samples = 13'd1;
            if (bus.busy) begin
                if (busy_first == 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (bus.sel_mux_wej !== bus.busy || bus.sel_mux_wyj !== bus.busy) sel_bad++;
            if (bus.result_wr) begin
                wr_cyc.push_back(c);
                ymem[bus.result_addr] = bus.result_data;
            end
            if (bus.done) begin
                dcyc = c;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b1;
        #2 a_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sample_addr, bus.coef_addr, bus.result_addr, bus.result_data, bus.result_wr,
             bus.sel_mux_wej, bus.sel_mux_wyj, bus.busy, bus.done} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got sa=%0d ca=%0d ra=%0d rd=%0d wr=%b wej=%b wyj=%b busy=%b done=%b, expected all 0",
                     bus.sample_addr, bus.coef_addr, bus.result_addr, bus.result_data, bus.result_wr,
                     bus.sel_mux_wej, bus.sel_mux_wyj, bus.busy, bus.done);
        end
        repeat (2) @(negedge a_clk);
        a_rst_n = 1'b1;
    endtask

    task automatic load_impulse();
        xmem[0] = 16'sd32767; xmem[1] = 16'sd0; xmem[2] = 16'sd0; xmem[3] = 16'sd0;
        hmem[0] = 16'sd16384; hmem[1] = 16'sd8192;
    endtask

    task automatic test_impulse();
        int exp_y[4] = '{16383, 8191, 0, 0};
        load_impulse();
        clear_y();
        run(4, 2, 0);
        checks++;
        if (dcyc !== 17) begin errs++; $display("FAIL imp_done_cycle: got %0d expected 17", dcyc); end
        checks++;
        if (wr_cyc.size() !== 4) begin errs++; $display("FAIL imp_write_count: got %0d expected 4", wr_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ymem[i] !== 21'(exp_y[i])) begin
                errs++;
                $display("FAIL imp_y%0d: got %0d expected %0d", i, ymem[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_exact_timing();
        int exp_w[3] = '{6, 12, 18};
        int exp_y[3] = '{-2, 0, 3};
        xmem[0] = -16'sd3; xmem[1] = 16'sd4; xmem[2] = 16'sd6;
        for (int i = 0; i < 4; i++) hmem[i] = 16'sd16384;
        clear_y();
        run(3, 4, 0);
        checks++;
        if (dcyc !== 19) begin errs++; $display("FAIL tim_done_cycle: got %0d expected 19", dcyc); end
        checks++;
        if (wr_cyc.size() !== 3) begin errs++; $display("FAIL tim_write_count: got %0d expected 3", wr_cyc.size()); end
        for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
            checks++;
            if (wr_cyc[i] !== exp_w[i]) begin errs++; $display("FAIL tim_wr_cycle%0d: got %0d expected %0d", i, wr_cyc[i], exp_w[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ymem[i] !== 21'(exp_y[i])) begin errs++; $display("FAIL tim_y%0d: got %0d expected %0d", i, ymem[i], exp_y[i]); end
        end
        checks++;
        if (busy_first !== 1 || busy_last !== 18 || busy_cnt !== 18) begin
            errs++;
            $display("FAIL tim_busy_window: got first=%0d last=%0d count=%0d expected 1 18 18", busy_first, busy_last, busy_cnt);
        end
        checks++;
        if (sel_bad !== 0) begin errs++; $display("FAIL tim_sel_mux: got %0d cycles differing from busy, expected 0", sel_bad); end
        @(negedge a_clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL tim_after_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_saturation();
        int exp_p[3] = '{32766, 1048512, 1048575};
        int exp_n[3] = '{-32767, -1048544, -1048576};
        int idx[3]   = '{0, 31, 62};
        for (int i = 0; i < 63; i++) begin hmem[i] = 16'sd32767; xmem[i] = 16'sd32767; end
        clear_y();
        run(63, 63, 0);
        checks++;
        if (dcyc !== 4096) begin errs++; $display("FAIL satp_done_cycle: got %0d expected 4096", dcyc); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ymem[idx[i]] !== 21'(exp_p[i])) begin errs++; $display("FAIL satp_y%0d: got %0d expected %0d", idx[i], ymem[idx[i]], exp_p[i]); end
        end
        for (int i = 0; i < 63; i++) xmem[i] = -16'sd32768;
        clear_y();
        run(63, 63, 0);
        checks++;
        if (wr_cyc.size() !== 63) begin errs++; $display("FAIL satn_write_count: got %0d expected 63", wr_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ymem[idx[i]] !== 21'(exp_n[i])) begin errs++; $display("FAIL satn_y%0d: got %0d expected %0d", idx[i], ymem[idx[i]], exp_n[i]); end
        end
    endtask

    task automatic test_zero_length();
        int ns[2] = '{0, 5};
        int ts[2] = '{5, 0};
        for (int i = 0; i < 2; i++) begin
            run(ns[i], ts[i], 0);
            checks++;
            if (dcyc !== 1) begin errs++; $display("FAIL zero%0d_done_cycle: got %0d expected 1", i, dcyc); end
            checks++;
            if (wr_cyc.size() !== 0 || busy_cnt !== 0 || sel_bad !== 0) begin
                errs++;
                $display("FAIL zero%0d_activity: got writes=%0d busy=%0d sel_bad=%0d expected 0 0 0", i, wr_cyc.size(), busy_cnt, sel_bad);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int exp_y[4] = '{16383, 8191, 0, 0};
        load_impulse();
        clear_y();
        run(4, 2, 5);
        checks++;
        if (dcyc !== 17) begin errs++; $display("FAIL swb_done_cycle: got %0d expected 17", dcyc); end
        checks++;
        if (wr_cyc.size() !== 4) begin errs++; $display("FAIL swb_write_count: got %0d expected 4", wr_cyc.size()); end
        for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
            checks++;
            if (wr_cyc[i] !== 4 * (i + 1)) begin errs++; $display("FAIL swb_wr_cycle%0d: got %0d expected %0d", i, wr_cyc[i], 4 * (i + 1)); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ymem[i] !== 21'(exp_y[i])) begin errs++; $display("FAIL swb_y%0d: got %0d expected %0d", i, ymem[i], exp_y[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        int exp_y[4] = '{16383, 8191, 0, 0};
        int wr_seen;
        load_impulse();
        clear_y();
        @(negedge a_clk);
        bus.num_samples = 13'd2;
        bus.num_taps    = 6'd3;
        bus.start       = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge a_clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.result_wr !== 1'b0 || bus.coef_addr !== '0) begin
            errs++;
            $display("FAIL rst_drain_state: got busy=%b wr=%b ca=%0d expected 1 0 0", bus.busy, bus.result_wr, bus.coef_addr);
        end
        #1 a_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sample_addr, bus.coef_addr, bus.result_addr, bus.result_data, bus.result_wr,
             bus.sel_mux_wej, bus.sel_mux_wyj, bus.busy, bus.done} !== '0) begin
            errs++;
            $display("FAIL rst_mid_outputs: got wr=%b busy=%b wej=%b wyj=%b done=%b expected all 0",
                     bus.result_wr, bus.busy, bus.sel_mux_wej, bus.sel_mux_wyj, bus.done);
        end
        wr_seen = 0;
        repeat (3) begin
            @(negedge a_clk);
            if (bus.result_wr !== 1'b0) wr_seen++;
        end
        a_rst_n = 1'b1;
        checks++;
        if (wr_seen !== 0) begin errs++; $display("FAIL rst_no_write: got %0d write cycles expected 0", wr_seen); end
        run(4, 2, 0);
        checks++;
        if (dcyc !== 17) begin errs++; $display("FAIL rst_fresh_done_cycle: got %0d expected 17", dcyc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ymem[i] !== 21'(exp_y[i])) begin errs++; $display("FAIL rst_fresh_y%0d: got %0d expected %0d", i, ymem[i], exp_y[i]); end
        end
    endtask

    initial begin
        checks = 0;
        errs = 0;
        bus.start = 1'b0;
        bus.num_samples = '0;
        bus.num_taps = '0;
        for (int i = 0; i < 8192; i++) begin xmem[i] = '0; hmem[i] = '0; ymem[i] = '0; end
        test_reset();
        test_impulse();
        test_exact_timing();
        test_saturation();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
